// File: rtl/v2f_op_scheduler.sv
// Round-robin scheduler sharing one v2f arithmetic cell among N_REQ requesters, with a tag pipe
// routing each result back to its issuer. Define V2F_SCHED_DIV0_TRAP_EN to trap DIV/MOD by zero.
module v2f_op_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int OP_W    = 4,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ*WIDTH-1:0] rsp_y,
  output logic [N_REQ-1:0]       rsp_err,
  output logic                   u_valid,
  output logic [OP_W-1:0]        u_op,
  output logic [WIDTH-1:0]       u_a,
  output logic [WIDTH-1:0]       u_b,
  input  logic [WIDTH-1:0]       u_y
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] eligible;
  logic             gnt_hit;
  logic             gnt_trap;
  logic [ID_W-1:0]  gnt_id;
  logic [OP_W-1:0]  gnt_op;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;
  int               arb_idx;

  logic             tag_vld_p  [LATENCY];
  logic             tag_trap_p [LATENCY];
  logic [ID_W-1:0]  tag_id_p   [LATENCY];
  logic             tail_vld;
  logic             tail_trap;
  logic [ID_W-1:0]  tail_id;

  // Gating with arst_n keeps REQ_READY low while reset is held.
  assign eligible = req_valid & ~busy & {N_REQ{arst_n}};

  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    arb_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_hit && eligible[arb_idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = ID_W'(arb_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_hit) req_ready[gnt_id] = 1'b1;
  end

  assign gnt_op = req_op[gnt_id*OP_W +: OP_W];
  assign gnt_a  = req_a[gnt_id*WIDTH +: WIDTH];
  assign gnt_b  = req_b[gnt_id*WIDTH +: WIDTH];

`ifdef V2F_SCHED_DIV0_TRAP_EN
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(4);
  assign gnt_trap = gnt_hit && ((gnt_op == OP_DIV) || (gnt_op == OP_MOD)) && (gnt_b == '0);
`else
  assign gnt_trap = 1'b0;
`endif

  // Stage p0: issue to the shared cell; operand registers hold when nothing is granted.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr     <= '0;
      u_valid <= 1'b0;
      u_op    <= '0;
      u_a     <= '0;
      u_b     <= '0;
    end else begin
      u_valid <= gnt_hit & ~gnt_trap;
      if (gnt_hit) begin
        ptr  <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        u_op <= gnt_op;
        u_a  <= gnt_a;
        u_b  <= gnt_b;
      end
    end
  end

  // Tag pipe: LATENCY stages, trapped ops travel too so their slot is still answered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_vld_p[s]  <= 1'b0;
        tag_trap_p[s] <= 1'b0;
        tag_id_p[s]   <= '0;
      end
    end else begin
      tag_vld_p[0]  <= gnt_hit;
      tag_trap_p[0] <= gnt_trap;
      tag_id_p[0]   <= gnt_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_p[s]  <= tag_vld_p[s-1];
        tag_trap_p[s] <= tag_trap_p[s-1];
        tag_id_p[s]   <= tag_id_p[s-1];
      end
    end
  end

  assign tail_vld  = tag_vld_p[LATENCY-1];
  assign tail_trap = tag_trap_p[LATENCY-1];
  assign tail_id   = tag_id_p[LATENCY-1];

  // Response stage: one result slot per requester, busy spans grant to consumption.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy      <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_hit && (gnt_id == ID_W'(i))) busy[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i]) busy[i] <= 1'b0;
        if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
        if (tail_vld && (tail_id == ID_W'(i))) begin
          rsp_valid[i]              <= 1'b1;
          rsp_y[i*WIDTH +: WIDTH]   <= tail_trap ? '0 : u_y;
        end
      end
    end
  end

`ifdef V2F_SCHED_DIV0_TRAP_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_err <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) rsp_err[i] <= 1'b0;
        if (tail_vld && (tail_id == ID_W'(i))) rsp_err[i] <= tail_trap;
      end
    end
  end
`else
  assign rsp_err = '0;
`endif

  // A pending request must keep its valid and operands until granted.
  for (genvar i = 0; i < N_REQ; i++) begin : g_sticky
    a_sticky: assert property (@(posedge clk) disable iff (!arst_n)
      (req_valid[i] && !req_ready[i]) |=> (req_valid[i]
        && $stable(req_op[i*OP_W +: OP_W]) && $stable(req_a[i*WIDTH +: WIDTH])
        && $stable(req_b[i*WIDTH +: WIDTH])));
  end

endmodule
